axi_rd_scheduler: RTL and testbench

AXI_RD_SCHEDULER -- requirements
Module: axi_rd_scheduler

---
 rtl/axi_rd_scheduler.sv | 156 +++++++++++++++
 tb/tb_axi_rd_scheduler.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_scheduler.sv
// Read-burst scheduler: splits a transfer request into bursts of at most MAX_BURST beats.
// Optional macro RD_4K_SPLIT_EN additionally keeps every burst inside one 4 KiB page.
module axi_rd_scheduler #(
  parameter int unsigned MAX_BURST  = 16,
  parameter int unsigned BEAT_BYTES = 8
) (
  input  logic        ACLK,
  input  logic        ARESETN,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic [31:0] REQ_ADRS,
  input  logic [31:0] REQ_BEATS,
  output logic        REQ_DONE,
  input  logic        ABORT,
  output logic        BUSY,
  input  logic [15:0] FIFO_SPACE,
  output logic        RD_START,
  output logic [31:0] RD_ADRS,
  output logic [31:0] RD_LEN,
  input  logic        RD_READY,
  input  logic        RD_DONE,
  output logic [15:0] BURST_CNT
);

  typedef enum logic [2:0] {
    StIdle,
    StCalc,
    StWaitSpace,
    StIssue,
    StWaitDone,
    StFinish
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] cur_adrs_q, cur_adrs_d;
  logic [31:0] remaining_q, remaining_d;
  logic [31:0] len_q, len_d;
  logic [31:0] rd_adrs_q, rd_adrs_d;
  logic [31:0] rd_len_q, rd_len_d;
  logic [15:0] burst_cnt_q, burst_cnt_d;
  logic        abort_q, abort_d;

  logic        abort_seen;
  logic [31:0] max_len;
  logic [31:0] len_rem;
  logic [31:0] len_calc;

  // An ABORT arriving in the current cycle counts as seen, not only the latched copy.
  assign abort_seen = abort_q | ABORT;
  assign max_len    = 32'(MAX_BURST);
  assign len_rem    = (remaining_q < max_len) ? remaining_q : max_len;

`ifdef RD_4K_SPLIT_EN
  logic [31:0] page_room;
  assign page_room = (32'd4096 - {20'd0, cur_adrs_q[11:0]}) / 32'(BEAT_BYTES);
  assign len_calc  = (len_rem < page_room) ? len_rem : page_room;
`else
  assign len_calc  = len_rem;
`endif

  always_comb begin
    state_d     = state_q;
    cur_adrs_d  = cur_adrs_q;
    remaining_d = remaining_q;
    len_d       = len_q;
    rd_adrs_d   = rd_adrs_q;
    rd_len_d    = rd_len_q;
    burst_cnt_d = burst_cnt_q;

    unique case (state_q)
      StIdle: begin
        if (REQ_VALID) begin
          cur_adrs_d  = REQ_ADRS;
          remaining_d = REQ_BEATS;
          burst_cnt_d = '0;
          state_d     = StCalc;
        end
      end
      StCalc: begin
        if (remaining_q == 32'd0 || abort_seen) begin
          state_d = StFinish;
        end else begin
          len_d   = len_calc;
          state_d = StWaitSpace;
        end
      end
      StWaitSpace: begin
        if (abort_seen) begin
          state_d = StFinish;
        end else if ({16'd0, FIFO_SPACE} >= len_q && RD_READY) begin
          rd_adrs_d = cur_adrs_q;
          rd_len_d  = len_q;
          state_d   = StIssue;
        end
      end
      StIssue: begin
        burst_cnt_d = burst_cnt_q + 16'd1;
        state_d     = StWaitDone;
      end
      StWaitDone: begin
        // A pending abort never cuts the in-flight burst short; it is honoured here.
        if (RD_DONE) begin
          cur_adrs_d  = cur_adrs_q + len_q * 32'(BEAT_BYTES);
          remaining_d = remaining_q - len_q;
          state_d     = (remaining_d == 32'd0 || abort_seen) ? StFinish : StCalc;
        end
      end
      StFinish: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    abort_d = abort_q;
    if (state_q == StFinish) begin
      abort_d = 1'b0;
    end else if (state_q != StIdle && ABORT) begin
      abort_d = 1'b1;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q     <= StIdle;
      cur_adrs_q  <= '0;
      remaining_q <= '0;
      len_q       <= '0;
      rd_adrs_q   <= '0;
      rd_len_q    <= '0;
      burst_cnt_q <= '0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_adrs_q  <= cur_adrs_d;
      remaining_q <= remaining_d;
      len_q       <= len_d;
      rd_adrs_q   <= rd_adrs_d;
      rd_len_q    <= rd_len_d;
      burst_cnt_q <= burst_cnt_d;
      abort_q     <= abort_d;
    end
  end

  assign REQ_READY = (state_q == StIdle);
  assign BUSY      = (state_q != StIdle);
  assign REQ_DONE  = (state_q == StFinish);
  assign RD_START  = (state_q == StIssue);
  assign RD_ADRS   = rd_adrs_q;
  assign RD_LEN    = rd_len_q;
  assign BURST_CNT = burst_cnt_q;

endmodule

// File: tb/tb_axi_rd_scheduler.sv
// Scoreboard bench for axi_rd_scheduler: expected bursts and completions are queued by the
// stimulus and consumed by an independent monitor; a simple read-master model answers bursts.
module tb_axi_rd_scheduler;

  localparam int unsigned MaxBurst = 16;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic        REQ_VALID = 1'b0;
  logic        REQ_READY;
  logic [31:0] REQ_ADRS = '0;
  logic [31:0] REQ_BEATS = '0;
  logic        REQ_DONE;
  logic        ABORT = 1'b0;
  logic        BUSY;
  logic [15:0] FIFO_SPACE = 16'd256;
  logic        RD_START;
  logic [31:0] RD_ADRS;
  logic [31:0] RD_LEN;
  logic        RD_READY = 1'b1;
  logic        RD_DONE = 1'b0;
  logic [15:0] BURST_CNT;

  axi_rd_scheduler #(
    .MAX_BURST (MaxBurst),
    .BEAT_BYTES(8)
  ) dut (
    .ACLK      (ACLK),
    .ARESETN   (ARESETN),
    .REQ_VALID (REQ_VALID),
    .REQ_READY (REQ_READY),
    .REQ_ADRS  (REQ_ADRS),
    .REQ_BEATS (REQ_BEATS),
    .REQ_DONE  (REQ_DONE),
    .ABORT     (ABORT),
    .BUSY      (BUSY),
    .FIFO_SPACE(FIFO_SPACE),
    .RD_START  (RD_START),
    .RD_ADRS   (RD_ADRS),
    .RD_LEN    (RD_LEN),
    .RD_READY  (RD_READY),
    .RD_DONE   (RD_DONE),
    .BURST_CNT (BURST_CNT)
  );

  always #5 ACLK = ~ACLK;

  typedef struct packed {
    logic [31:0] adrs;
    logic [31:0] len;
  } burst_t;

  burst_t exp_bursts[$];
  int     exp_done[$];
  int     checks = 0;
  int     errors = 0;
  int     start_count = 0;

  // Read-master model controls
  bit          auto_master = 1'b1;
  bit          rand_space = 1'b0;
  logic [15:0] fixed_space = 16'd256;
  int          done_req = 0;
  int          done_ack = 0;
  int          busy_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference plan: split into bursts by beat budget, MAX_BURST and (optionally) 4 KiB pages.
  task automatic plan(input logic [31:0] adrs, input logic [31:0] beats);
    logic [31:0] a = adrs;
    longint      rem = beats;
    longint      l;
    int          n = 0;
    burst_t      b;
    while (rem > 0) begin
      l = (rem < MaxBurst) ? rem : MaxBurst;
`ifdef RD_4K_SPLIT_EN
      if (l > (4096 - (a % 4096)) / 8) l = (4096 - (a % 4096)) / 8;
`endif
      b.adrs = a;
      b.len  = 32'(l);
      exp_bursts.push_back(b);
      a   = a + 32'(l * 8);
      rem = rem - l;
      n++;
    end
    exp_done.push_back(n);
  endtask

  task automatic push_burst(input logic [31:0] adrs, input logic [31:0] len);
    burst_t b;
    b.adrs = adrs;
    b.len  = len;
    exp_bursts.push_back(b);
  endtask

  task automatic request(input logic [31:0] adrs, input logic [31:0] beats);
    int n = 0;
    @(negedge ACLK);
    while (!REQ_READY && n < 200) begin
      @(negedge ACLK);
      n++;
    end
    chk("req_ready_before_request", {31'd0, REQ_READY}, 32'd1);
    REQ_VALID = 1'b1;
    REQ_ADRS  = adrs;
    REQ_BEATS = beats;
    @(negedge ACLK);
    REQ_VALID = 1'b0;
  endtask

  task automatic wait_all();
    int n = 0;
    while ((exp_done.size() != 0 || exp_bursts.size() != 0) && n < 3000) begin
      @(negedge ACLK);
      n++;
    end
    checks++;
    if (n >= 3000) begin
      errors++;
      $display("FAIL request_timeout: bursts left %0d dones left %0d expected 0 and 0",
               exp_bursts.size(), exp_done.size());
      exp_bursts.delete();
      exp_done.delete();
    end
    @(negedge ACLK);
  endtask

  task automatic wait_start();
    int n = 0;
    while (!RD_START && n < 200) begin
      @(negedge ACLK);
      n++;
    end
    chk("rd_start_seen", {31'd0, RD_START}, 32'd1);
  endtask

  // Read master: idle until RD_START, then completes after a random 1..4 cycle delay.
  always @(negedge ACLK) begin
    RD_DONE = 1'b0;
    if (done_req != done_ack) begin
      RD_DONE  = 1'b1;
      done_ack = done_req;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) RD_DONE = 1'b1;
    end
    if (ARESETN && RD_START && auto_master) busy_cnt = $urandom_range(1, 4);
    RD_READY   = (busy_cnt == 0);
    FIFO_SPACE = rand_space ? 16'($urandom_range(0, 40)) : fixed_space;
  end

  // Monitor: every observed burst start and completion must match the next expectation.
  always @(negedge ACLK) begin
    if (ARESETN) begin
      if (RD_START) begin
        burst_t e;
        start_count++;
        checks++;
        if (exp_bursts.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rd_start: got adrs 0x%08h len %0d expected no burst",
                   RD_ADRS, RD_LEN);
        end else begin
          e = exp_bursts.pop_front();
          if (RD_ADRS !== e.adrs || RD_LEN !== e.len) begin
            errors++;
            $display("FAIL burst: got adrs 0x%08h len %0d expected adrs 0x%08h len %0d",
                     RD_ADRS, RD_LEN, e.adrs, e.len);
          end
        end
      end
      if (REQ_DONE) begin
        int c;
        checks++;
        if (exp_done.size() == 0) begin
          errors++;
          $display("FAIL unexpected_req_done: got pulse with BURST_CNT %0d expected none",
                   BURST_CNT);
        end else begin
          c = exp_done.pop_front();
          if (exp_bursts.size() != 0 || BURST_CNT !== 16'(c)) begin
            errors++;
            $display("FAIL req_done: got BURST_CNT %0d pending %0d expected BURST_CNT %0d pending 0",
                     BURST_CNT, exp_bursts.size(), c);
          end
        end
      end
    end
  end

  initial begin
    int sc;
    logic [31:0] a;
    logic [31:0] beats;

    #2;
    chk("reset_req_ready", {31'd0, REQ_READY}, 32'd1);
    chk("reset_busy", {31'd0, BUSY}, 32'd0);
    chk("reset_rd_start", {31'd0, RD_START}, 32'd0);
    chk("reset_rd_len", RD_LEN, 32'd0);
    chk("reset_burst_cnt", {16'd0, BURST_CNT}, 32'd0);
    repeat (3) @(negedge ACLK);
    ARESETN = 1'b1;

    // Basic split into MAX_BURST pieces
    push_burst(32'h1000, 16);
    push_burst(32'h1080, 16);
    push_burst(32'h1100, 8);
    exp_done.push_back(3);
    request(32'h1000, 40);
    wait_all();
    chk("burst_cnt_holds", {16'd0, BURST_CNT}, 32'd3);
    chk("idle_after_done", {31'd0, BUSY}, 32'd0);

    // Page boundary behaviour
`ifdef RD_4K_SPLIT_EN
    push_burst(32'h0FF0, 2);
    push_burst(32'h1000, 8);
    exp_done.push_back(2);
`else
    push_burst(32'h0FF0, 10);
    exp_done.push_back(1);
`endif
    request(32'h0FF0, 10);
    wait_all();

    // Zero-beat request
    exp_done.push_back(0);
    request(32'h2000, 0);
    wait_all();
    chk("zero_beats_burst_cnt", {16'd0, BURST_CNT}, 32'd0);

    // Insufficient FIFO space blocks issue
    fixed_space = 16'd4;
    repeat (2) @(negedge ACLK);
    push_burst(32'h4000, 16);
    exp_done.push_back(1);
    sc = start_count;
    request(32'h4000, 16);
    repeat (10) @(negedge ACLK);
    chk("no_start_low_space", 32'(start_count), 32'(sc));
    fixed_space = 16'd16;
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 2; i++) begin
        @(negedge ACLK);
        if (RD_START) seen = 1'b1;
      end
      chk("start_after_space", {31'd0, seen}, 32'd1);
    end
    wait_all();
    fixed_space = 16'd256;

    // Abort during the first burst
    push_burst(32'h3000, 16);
    exp_done.push_back(1);
    request(32'h3000, 40);
    wait_start();
    @(negedge ACLK);
    ABORT = 1'b1;
    @(negedge ACLK);
    ABORT = 1'b0;
    wait_all();
    chk("abort_burst_cnt", {16'd0, BURST_CNT}, 32'd1);

    // A fresh request after abort must run in full
    plan(32'h5000, 20);
    request(32'h5000, 20);
    wait_all();

    // Randomised requests with fluctuating FIFO space
    rand_space = 1'b1;
    for (int i = 0; i < 25; i++) begin
      case ($urandom_range(0, 2))
        0: a = $urandom & 32'hFFFF_FFF8;
        1: a = ($urandom & 32'hFFFF_F000) + 32'h0F80 + 32'(8 * $urandom_range(0, 15));
        default: a = 32'hFFFF_FF80 + 32'(8 * $urandom_range(0, 15));
      endcase
      beats = 32'($urandom_range(0, 60));
      plan(a, beats);
      request(a, beats);
      wait_all();
    end
    rand_space = 1'b0;

    // Reset while a burst is outstanding
    auto_master = 1'b0;
    push_burst(32'h6000, 16);
    request(32'h6000, 40);
    wait_start();
    repeat (3) @(negedge ACLK);
    ARESETN = 1'b0;
    #1;
    chk("midreset_req_ready", {31'd0, REQ_READY}, 32'd1);
    chk("midreset_req_done", {31'd0, REQ_DONE}, 32'd0);
    chk("midreset_busy", {31'd0, BUSY}, 32'd0);
    chk("midreset_rd_start", {31'd0, RD_START}, 32'd0);
    chk("midreset_rd_adrs", RD_ADRS, 32'd0);
    chk("midreset_rd_len", RD_LEN, 32'd0);
    chk("midreset_burst_cnt", {16'd0, BURST_CNT}, 32'd0);
    @(negedge ACLK);
    ARESETN = 1'b1;
    sc = start_count;
    done_req++;
    repeat (10) @(negedge ACLK);
    chk("post_reset_busy", {31'd0, BUSY}, 32'd0);
    chk("post_reset_ready", {31'd0, REQ_READY}, 32'd1);
    chk("post_reset_no_start", 32'(start_count), 32'(sc));
    chk("post_reset_burst_cnt", {16'd0, BURST_CNT}, 32'd0);
    auto_master = 1'b1;

    // Scheduler still usable after reset
    plan(32'h7000, 17);
    request(32'h7000, 17);
    wait_all();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
